mem_port_arbiter: RTL

Shares the single unified memory port between the instruction-fetch stage and the memory stage of the pipelined RV32I core. Data requests come from the EX/MEM pipeline register: address, store data, read/write and load/store size. The block grants one requester at a time with a bounded-fairness priority rule and drives a registered request/ready memory bus. It returns read data with a one-cycle acknowledge and produces the stall signals that freeze the IF and MEM pipeline registers while an access is pending.

---
 rtl/mem_port_arbiter_pkg.sv | 32 +++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter.
//   arb_state_t : arbiter FSM states
//   arb_owner_t : which requester owns the completed bus access
//   mem_cmd_t   : registered memory bus command payload
package mem_port_arbiter_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned SIZE_W = 3;

    // funct3 encoding of a 32-bit access; instruction fetches always use it
    localparam logic [SIZE_W-1:0] LS_WORD = 3'b010;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [SIZE_W-1:0] size;
    } mem_cmd_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between instruction fetch and the
// memory stage, drives a registered request/ready bus, returns read data
// with a one-cycle ack and produces the IF/MEM stall signals.
// Ports:
//   clk, reset_n                 : clock, synchronous active-low reset
//   if_req/if_addr/if_kill       : fetch request, address, redirect kill
//   if_ack/if_rdata              : fetch completion pulse and instruction
//   d_req/d_we/d_addr/d_wdata/d_size : data request from EX/MEM
//   d_ack/d_rdata                : data completion pulse and raw load word
//   mem_req/mem_we/mem_addr/mem_wdata/mem_size : registered bus command
//   mem_ready/mem_rdata          : bus completion and read data
//   stall_if/stall_mem           : combinational pipeline freezes
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [XLEN-1:0]   if_addr,
    input  logic              if_kill,
    output logic              if_ack,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [SIZE_W-1:0] d_size,
    output logic              d_ack,
    output logic [XLEN-1:0]   d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [SIZE_W-1:0] mem_size,
    input  logic              mem_ready,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              stall_if,
    output logic              stall_mem
);

    // +2 keeps the width at least one bit even for MAX_D_STREAK == 0
    localparam int unsigned            STREAK_W   = $clog2(MAX_D_STREAK + 2);
    localparam logic [STREAK_W-1:0]    STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_t          state, state_n;
    arb_owner_t          owner, owner_n;
    mem_cmd_t            cmd, cmd_n;
    logic                mem_req_n;
    logic                if_ack_n, d_ack_n;
    logic [XLEN-1:0]     if_rdata_n, d_rdata_n;
    logic [STREAK_W-1:0] d_streak, d_streak_n;
    logic                kill, kill_n;
    logic                fetch_pend;
    logic                streak_full;

    // A killed fetch is treated as no fetch at all during arbitration
    assign fetch_pend  = if_req & ~if_kill;
    assign streak_full = (d_streak == STREAK_MAX);

    assign mem_we    = cmd.we;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;
    assign mem_size  = cmd.size;

    assign stall_if  = if_req & ~if_ack;
    assign stall_mem = d_req & ~d_ack;

    // Next-state and next-register values
    always_comb begin
        state_n    = state;
        owner_n    = owner;
        cmd_n      = cmd;
        mem_req_n  = mem_req;
        if_ack_n   = 1'b0;
        d_ack_n    = 1'b0;
        if_rdata_n = if_rdata;
        d_rdata_n  = d_rdata;
        d_streak_n = d_streak;
        kill_n     = kill;

        case (state)
            IDLE: begin
                if (d_req && !(fetch_pend && streak_full)) begin
                    cmd_n.we    = d_we;
                    cmd_n.addr  = d_addr;
                    cmd_n.wdata = d_wdata;
                    cmd_n.size  = d_size;
                    mem_req_n   = 1'b1;
                    state_n     = DATA;
                    // Only count data wins that made a fetch wait
                    if (!fetch_pend) begin
                        d_streak_n = '0;
                    end else if (!streak_full) begin
                        d_streak_n = d_streak + STREAK_W'(1);
                    end
                end else if (fetch_pend) begin
                    cmd_n.we   = 1'b0;
                    cmd_n.addr = if_addr;
                    cmd_n.size = LS_WORD;
                    mem_req_n  = 1'b1;
                    d_streak_n = '0;
                    state_n    = FETCH;
                end
            end
            FETCH: begin
                if (if_kill) begin
                    kill_n = 1'b1;
                end
                if (mem_ready) begin
                    // Killed fetch still consumes the bus beat; only the ack is dropped
                    if_rdata_n = mem_rdata;
                    if_ack_n   = ~(kill | if_kill);
                    owner_n    = OWN_IF;
                    mem_req_n  = 1'b0;
                    state_n    = RESP;
                end
            end
            DATA: begin
                if (mem_ready) begin
                    d_rdata_n = mem_rdata;
                    d_ack_n   = 1'b1;
                    owner_n   = OWN_D;
                    mem_req_n = 1'b0;
                    state_n   = RESP;
                end
            end
            RESP: begin
                kill_n  = 1'b0;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            owner    <= OWN_IF;
            cmd      <= '0;
            mem_req  <= 1'b0;
            if_ack   <= 1'b0;
            d_ack    <= 1'b0;
            if_rdata <= '0;
            d_rdata  <= '0;
            d_streak <= '0;
            kill     <= 1'b0;
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            cmd      <= cmd_n;
            mem_req  <= mem_req_n;
            if_ack   <= if_ack_n;
            d_ack    <= d_ack_n;
            if_rdata <= if_rdata_n;
            d_rdata  <= d_rdata_n;
            d_streak <= d_streak_n;
            kill     <= kill_n;
        end
    end

endmodule
